sub9u_serial_recover: RTL and testbench

Bit-serial unsigned subtractor that inverts the 8-bit unsigned adder: given a 9-bit sum O[8:0] and the operand B[7:0], it recovers A = O − B over W+1 cycles and flags sums that no W-bit A can produce. It is a low-area, fault-checking companion placed downstream of adder outputs: it re-derives an operand and signals consistency errors. Valid/ready handshakes on both sides; one operation in flight.

---
 rtl/sub_serial_pkg.sv | 17 +
 rtl/sub9u_serial_recover_fsub1.sv | 13 +
 rtl/sub9u_serial_recover.sv | 108 ++++++++++
 tb/tb_sub9u_serial_recover.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sub_serial_pkg.sv
// Shared types and sizing helpers for the bit-serial sum-recovery subtractor.
package sub_serial_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter must hold 0..W, the last step index of a (W+1)-step operation.
  function automatic int cnt_w(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/sub9u_serial_recover_fsub1.sv
// Combinational 1-bit full subtractor: d = s - b - bin, with borrow out.
module fsub1 (
  input  logic s,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = s ^ b ^ bin;
  assign bout = (~s & b) | (~(s ^ b) & bin);

endmodule

// File: rtl/sub9u_serial_recover.sv
// Recovers A = O - B bit-serially over W+1 cycles and flags sums no W-bit A can produce.
module sub9u_serial_recover
  import sub_serial_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:0]   sum_i,
  input  logic [W-1:0] b_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] a_o,
  output logic         err_o
);

  localparam int CW = cnt_w(W);

  state_e          state_q, state_d;
  logic [W:0]      s_q, s_d;
  logic [W:0]      b_q, b_d;
  logic [W-1:0]    d_q, d_d;
  logic            bor_q, bor_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic            err_q, err_d;
  logic            step_d, step_bout;

  fsub1 u_fsub1 (
    .s    (s_q[0]),
    .b    (b_q[0]),
    .bin  (bor_q),
    .d    (step_d),
    .bout (step_bout)
  );

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    d_d     = d_q;
    bor_d   = bor_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = sum_i;
          b_d     = {1'b0, b_i};
          d_d     = '0;
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        s_d   = s_q >> 1;
        b_d   = b_q >> 1;
        d_d   = {step_d, d_q[W-1:1]};
        bor_d = step_bout;
        cnt_d = cnt_q + CW'(1);
        // The final difference bit is D[W]; it is consumed live and never stored.
        if (cnt_q == CW'(W)) begin
          a_d     = d_q;
          err_d   = step_bout | step_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      bor_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      d_q     <= d_d;
      bor_q   <= bor_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign a_o       = a_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_sub9u_serial_recover.sv
// Randomized and directed bench for sub9u_serial_recover against an arithmetic model.
module tb_sub9u_serial_recover;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] sum_i;
  logic [7:0] b_i;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] a_o;
  logic       err_o;

  int n_vec = 0;
  int n_err = 0;

  sub9u_serial_recover #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_i     (sum_i),
    .b_i       (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_o       (a_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  // Reference: A is the low byte of O - B; error when O < B or O - B exceeds a byte.
  task automatic model(input logic [8:0] s, input logic [7:0] b,
                       output logic [7:0] a, output logic err);
    logic [8:0] diff;
    diff = s - {1'b0, b};
    a    = diff[7:0];
    err  = (int'(s) < int'(b)) || ((int'(s) - int'(b)) > 255);
  endtask

  // Starts #1 after an edge in IDLE; returns edges from accept to out_valid and
  // the number of cycles where in_ready and out_valid were both high or in_ready rose early.
  task automatic do_op(input logic [8:0] s, input logic [7:0] b,
                       output int lat, output int viol);
    in_valid = 1'b1;
    sum_i    = s;
    b_i      = b;
    @(posedge clk); #1;
    lat  = 0;
    viol = 0;
    while (!out_valid && lat < 50) begin
      in_valid = 1'($urandom);
      sum_i    = 9'($urandom);
      b_i      = 8'($urandom);
      @(posedge clk); #1;
      lat++;
      if (in_ready) viol++;
    end
    in_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [8:0] s, input logic [7:0] b);
    int lat, viol;
    logic [7:0] ea;
    logic ee;
    model(s, b, ea, ee);
    do_op(s, b, lat, viol);
    n_vec++;
    if (lat !== 9) begin
      n_err++;
      $display("FAIL %s latency: got %0d expected 9", name, lat);
    end
    n_vec++;
    if (viol !== 0) begin
      n_err++;
      $display("FAIL %s in_ready during op: got %0d bad cycles expected 0", name, viol);
    end
    n_vec++;
    if (a_o !== ea || err_o !== ee) begin
      n_err++;
      $display("FAIL %s result sum=%h b=%h: got a=%h err=%b expected a=%h err=%b",
               name, s, b, a_o, err_o, ea, ee);
    end
    release_out();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || a_o !== ea || err_o !== ee) begin
      n_err++;
      $display("FAIL %s after release: got rdy=%b vld=%b a=%h err=%b expected 1 0 %h %b",
               name, in_ready, out_valid, a_o, err_o, ea, ee);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; sum_i = 9'h1AB; b_i = 8'h12;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || a_o !== 8'h00 || err_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset values: got rdy=%b vld=%b a=%h err=%b expected 1 0 00 0",
               in_ready, out_valid, a_o, err_o);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    check_op("basic",   9'h096, 8'h3C);
    check_op("max",     9'h1FE, 8'hFF);
    check_op("borrow",  9'h010, 8'h20);
    check_op("over",    9'h1FF, 8'h00);
    check_op("zero",    9'h000, 8'h00);
    check_op("equal",   9'h0FF, 8'hFF);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [8:0] s;
      logic [7:0] b;
      s = 9'($urandom_range(0, 511));
      b = 8'($urandom_range(0, 255));
      if (i % 4 == 0) s = {1'b0, b} + 9'($urandom_range(0, 255));
      check_op("random", s, b);
    end
  endtask

  task automatic test_back_to_back();
    int lat, viol;
    logic [7:0] ea;
    logic ee;
    model(9'h0C8, 8'h19, ea, ee);
    do_op(9'h0C8, 8'h19, lat, viol);
    n_vec++;
    if (lat !== 9 || a_o !== ea || err_o !== ee) begin
      n_err++;
      $display("FAIL b2b first: got lat=%0d a=%h err=%b expected 9 %h %b", lat, a_o, err_o, ea, ee);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      sum_i    = 9'($urandom);
      b_i      = 8'($urandom);
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || a_o !== ea || err_o !== ee) begin
        n_err++;
        $display("FAIL b2b hold cycle %0d: got vld=%b rdy=%b a=%h err=%b expected 1 0 %h %b",
                 i, out_valid, in_ready, a_o, err_o, ea, ee);
      end
    end
    in_valid = 1'b0;
    release_out();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b release: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
    end
    check_op("b2b second", 9'h1C0, 8'hE0);
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    in_valid = 1'b1; sum_i = 9'h123; b_i = 8'h45;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0; in_valid = 1'b1; sum_i = 9'h0AA; b_i = 8'h11;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || a_o !== 8'h00 || err_o !== 1'b0) begin
      n_err++;
      $display("FAIL mid reset: got rdy=%b vld=%b a=%h err=%b expected 1 0 00 0",
               in_ready, out_valid, a_o, err_o);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL mid reset quiet: got %0d active cycles expected 0", seen);
    end
    check_op("after reset", 9'h150, 8'h77);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
